// File: rtl/protocol_fsm.sv
// rtl/protocol_fsm.sv - token/data/handshake transaction sequencer with retry
// Purpose: runs one OUT (token, DATA0, wait ACK) or IN (token, wait DATA0, ACK)
//          transaction per start pulse, retrying failed attempts up to MAX_ATTEMPTS.
// Optional feature: define PROTO_TIMEOUT_EN to fail an attempt after TIMEOUT_CYCLES
//          clocks in RX_WAIT; without it RX_WAIT waits for a packet indefinitely.
// Ports:
//   clk, rst_b                  clock, synchronous active-low reset
//   start, is_in, addr, endp,   transaction request and its parameters
//   data_wr
//   data_rd                     payload of the last successful IN
//   busy, done, success         status; success valid with done, held until next start
//   pkt_in, pkt_in_avail        packet to datapath and one-cycle send strobe
//   encoder_ready, nrzi_avail   datapath accept / line transmit in progress
//   pkt_out, pkt_out_avail,     received packet, strobe and CRC status
//   data_good, decoder_ready
//   re                          1 = line in receive mode
module protocol_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_ATTEMPTS   = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic        is_in,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data_wr,
    output logic [63:0] data_rd,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [98:0] pkt_in,
    output logic        pkt_in_avail,
    input  logic        encoder_ready,
    input  logic        nrzi_avail,
    input  logic [98:0] pkt_out,
    input  logic        pkt_out_avail,
    input  logic        data_good,
    input  logic        decoder_ready,
    output logic        re
);
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    typedef enum logic [2:0] {
        IDLE, TX_TOKEN, TX_DATA, TX_ACK, TX_WAIT, RX_WAIT, FINISH
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_is_in;
    logic [6:0]     r_addr;
    logic [3:0]     r_endp;
    logic [63:0]    r_data_wr;
    logic [63:0]    r_data_rd;
    logic [AW-1:0]  r_attempt;
    logic           r_success;
    logic           r_nrzi_seen;
    logic [98:0]    r_pkt_in;

    logic           w_in_tx;
    logic           w_timeout;
    logic           w_fail;
    logic           w_load_pkt;
    logic [98:0]    w_pkt_nxt;
    logic           w_set_result;
    logic           w_result;
    logic           w_attempt_inc;
    logic           w_load_rd;
    logic [7:0]     w_rx_pid;
    logic [98:0]    w_token;
    logic           w_unused;

    assign w_in_tx  = (r_state == TX_TOKEN) || (r_state == TX_DATA) || (r_state == TX_ACK);
    assign w_rx_pid = pkt_out[98:91];
    // Retry tokens are rebuilt from the latched request, not the live inputs.
    assign w_token  = {(r_is_in ? PID_IN : PID_OUT), r_addr, r_endp, 80'd0};
    assign w_unused = ^{decoder_ready, pkt_out[90:80], pkt_out[15:0]};

`ifdef PROTO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;

    // Held at zero outside RX_WAIT so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst_b || r_state != RX_WAIT) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Last of TIMEOUT_CYCLES cycles in RX_WAIT; the retry token follows directly.
    assign w_timeout = (r_state == RX_WAIT) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_fail        = 1'b0;
        w_load_pkt    = 1'b0;
        w_pkt_nxt     = r_pkt_in;
        w_set_result  = 1'b0;
        w_result      = 1'b0;
        w_attempt_inc = 1'b0;
        w_load_rd     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = TX_TOKEN;
                    w_load_pkt  = 1'b1;
                    w_pkt_nxt   = {(is_in ? PID_IN : PID_OUT), addr, endp, 80'd0};
                end
            end
            TX_TOKEN, TX_DATA, TX_ACK: begin
                if (encoder_ready) begin
                    w_state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The PID of the packet just sent decides where to go next.
                if (r_nrzi_seen && !nrzi_avail) begin
                    case (r_pkt_in[98:91])
                        PID_OUT: begin
                            w_state_nxt = TX_DATA;
                            w_load_pkt  = 1'b1;
                            w_pkt_nxt   = {PID_DATA0, 11'd0, r_data_wr, 16'd0};
                        end
                        PID_ACK: begin
                            w_state_nxt  = FINISH;
                            w_set_result = 1'b1;
                            w_result     = 1'b1;
                        end
                        default: w_state_nxt = RX_WAIT;
                    endcase
                end
            end
            RX_WAIT: begin
                // A packet acted on in the expiry cycle beats the timeout.
                if (pkt_out_avail && !r_is_in) begin
                    if (data_good && w_rx_pid == PID_ACK) begin
                        w_state_nxt  = FINISH;
                        w_set_result = 1'b1;
                        w_result     = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (pkt_out_avail && data_good && w_rx_pid == PID_DATA0) begin
                    w_load_rd   = 1'b1;
                    w_state_nxt = TX_ACK;
                    w_load_pkt  = 1'b1;
                    w_pkt_nxt   = {PID_ACK, 91'd0};
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
                if (w_fail) begin
                    if (r_attempt < AW'(MAX_ATTEMPTS)) begin
                        w_attempt_inc = 1'b1;
                        w_state_nxt   = TX_TOKEN;
                        w_load_pkt    = 1'b1;
                        w_pkt_nxt     = w_token;
                    end else begin
                        w_state_nxt  = FINISH;
                        w_set_result = 1'b1;
                        w_result     = 1'b0;
                    end
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_is_in     <= 1'b0;
            r_addr      <= '0;
            r_endp      <= '0;
            r_data_wr   <= '0;
            r_data_rd   <= '0;
            r_attempt   <= '0;
            r_success   <= 1'b0;
            r_nrzi_seen <= 1'b0;
            r_pkt_in    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_is_in   <= is_in;
                r_addr    <= addr;
                r_endp    <= endp;
                r_data_wr <= data_wr;
                r_attempt <= AW'(1);
                r_success <= 1'b0;
            end
            if (w_attempt_inc) r_attempt <= r_attempt + 1'b1;
            if (w_load_pkt)    r_pkt_in  <= w_pkt_nxt;
            if (w_set_result)  r_success <= w_result;
            if (w_load_rd)     r_data_rd <= pkt_out[79:16];
            // Remembers the rising edge of nrzi_avail so its fall marks send complete.
            if (r_state != TX_WAIT) begin
                r_nrzi_seen <= 1'b0;
            end else if (nrzi_avail) begin
                r_nrzi_seen <= 1'b1;
            end
        end
    end

    assign data_rd      = r_data_rd;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == FINISH);
    assign success      = r_success;
    assign pkt_in       = r_pkt_in;
    assign pkt_in_avail = w_in_tx && encoder_ready;
    assign re           = !(w_in_tx || r_state == TX_WAIT);
endmodule

// File: tb/tb_protocol_fsm.sv
// tb/tb_protocol_fsm.sv - self-checking bench for protocol_fsm
`define CHK(t, o, e) chk(t, 128'(o), 128'(e))

module tb_protocol_fsm;
    localparam int TIMEOUT = 255;
    localparam int MAX_ATT = 8;
    localparam logic [7:0] PID_OUT = 8'hE1, PID_IN = 8'h69, PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK = 8'hD2, PID_NAK = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_b, start, is_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data_wr, data_rd;
    logic        busy, done, success;
    logic [98:0] pkt_in, pkt_out;
    logic        pkt_in_avail, encoder_ready, nrzi_avail, pkt_out_avail;
    logic        data_good, decoder_ready, re;

    int checks = 0;
    int errors = 0;

    logic [98:0] exp_q[$];
    logic        exp_ok;
    logic [63:0] model_rd;
    int          plan[MAX_ATT];
    int          tok_seen;
    logic        fast_tx;
    logic        junk_bad_only;
    logic        long_wait;

    protocol_fsm #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_ATTEMPTS(MAX_ATT)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .is_in(is_in), .addr(addr),
        .endp(endp), .data_wr(data_wr), .data_rd(data_rd), .busy(busy),
        .done(done), .success(success), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
        .encoder_ready(encoder_ready), .nrzi_avail(nrzi_avail), .pkt_out(pkt_out),
        .pkt_out_avail(pkt_out_avail), .data_good(data_good),
        .decoder_ready(decoder_ready), .re(re)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [98:0] rand99();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[98:0];
    endfunction

    task automatic fill_plan(int v);
        for (int i = 0; i < MAX_ATT; i++) plan[i] = v;
    endtask

    task automatic begin_txn(logic in_t, logic [6:0] a, logic [3:0] e, logic [63:0] wd);
        start = 1'b1; is_in = in_t; addr = a; endp = e; data_wr = wd;
        #1;
        `CHK("idle_before_start", busy, 1'b0);
        step();
        // Request fields are latched; scramble them to prove it.
        start = 1'b0;
        is_in = 1'($urandom_range(0, 1));
        addr = 7'($urandom); endp = 4'($urandom);
        data_wr = {$urandom(), $urandom()};
        #1;
        `CHK("busy_after_start", busy, 1'b1);
    endtask

    task automatic tx_phase(string tag);
        logic [98:0] e;
        int lat;
        int n = 0;
        logic was_fast;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
        was_fast = fast_tx;
        fast_tx = 1'b0;
        lat = was_fast ? 0 : $urandom_range(0, 3);
        encoder_ready = 1'b0;
        repeat (lat) begin
            #1;
            `CHK("no_strobe_encoder_busy", pkt_in_avail, 1'b0);
            step();
        end
        encoder_ready = 1'b1;
        #1;
        while (pkt_in_avail !== 1'b1 && n < 20) begin
            step(); #1; n++;
        end
        `CHK("strobe_seen", pkt_in_avail, 1'b1);
        if (was_fast) `CHK("retry_token_latency", n, 0);
        `CHK(tag, pkt_in, e);
        `CHK("re_low_tx", re, 1'b0);
        if (pkt_in[98:91] == PID_OUT || pkt_in[98:91] == PID_IN) tok_seen++;
        step();
        encoder_ready = 1'($urandom_range(0, 1));
        #1;
        `CHK("strobe_single_cycle", pkt_in_avail, 1'b0);
        repeat ($urandom_range(0, 2)) step();
        nrzi_avail = 1'b1;
        repeat ($urandom_range(1, 4)) begin
            #1;
            `CHK("re_low_line_busy", re, 1'b0);
            `CHK("pkt_in_stable", pkt_in, e);
            step();
        end
        nrzi_avail = 1'b0;
        #1;
        `CHK("no_strobe_tx_wait", pkt_in_avail, 1'b0);
        step();
    endtask

    task automatic rx_send(logic [7:0] pid, logic [63:0] d, logic good);
        repeat ($urandom_range(0, 4)) begin
            start = 1'($urandom_range(0, 1));
            pkt_out = rand99();
            data_good = 1'($urandom_range(0, 1));
            #1;
            `CHK("re_high_rx", re, 1'b1);
            `CHK("no_strobe_rx", pkt_in_avail, 1'b0);
            step();
        end
        start = 1'b0;
        pkt_out_avail = 1'b1;
        pkt_out = {pid, 7'($urandom), 4'($urandom), d, 16'($urandom)};
        data_good = good;
        #1;
        `CHK("re_high_reply", re, 1'b1);
        step();
        pkt_out_avail = 1'b0;
        data_good = 1'($urandom_range(0, 1));
    endtask

`ifdef PROTO_TIMEOUT_EN
    task automatic timeout_wait();
        int cnt = 0;
        encoder_ready = 1'b1;
        #1;
        while (re === 1'b1 && done !== 1'b1 && cnt < 1000) begin
            cnt++; step(); #1;
        end
        `CHK("timeout_cycles", cnt, TIMEOUT);
        fast_tx = 1'b1;
    endtask
`endif

    task automatic finish_check();
        int n = 0;
        start = 1'b0;
        #1;
        while (done !== 1'b1 && n < 20) begin
            step(); #1; n++;
        end
        `CHK("done_pulse", done, 1'b1);
        `CHK("success_with_done", success, exp_ok);
        `CHK("busy_in_finish", busy, 1'b1);
        step();
        #1;
        `CHK("done_one_cycle", done, 1'b0);
        `CHK("idle_after_done", busy, 1'b0);
        `CHK("success_held", success, exp_ok);
        `CHK("data_rd", data_rd, model_rd);
        `CHK("re_idle", re, 1'b1);
        `CHK("all_packets_sent", exp_q.size(), 0);
    endtask

    // Reference: attempt k sends a token (plus DATA0 for OUT); the first attempt whose
    // planned reply succeeds ends the transaction (IN also sends ACK); otherwise fail.
    task automatic run_txn(logic in_t, logic [6:0] a, logic [3:0] e,
                           logic [63:0] wd, logic [63:0] rd);
        int k;
        exp_q.delete();
        exp_ok = 1'b0;
        for (int att = 0; att < MAX_ATT; att++) begin
            exp_q.push_back({(in_t ? PID_IN : PID_OUT), a, e, 80'd0});
            if (!in_t) exp_q.push_back({PID_DATA0, 11'd0, wd, 16'd0});
            if (in_t ? (plan[att] >= 0) : (plan[att] == 0)) begin
                exp_ok = 1'b1;
                if (in_t) begin
                    exp_q.push_back({PID_ACK, 91'd0});
                    model_rd = rd;
                end
                break;
            end
        end
        tok_seen = 0;
        fast_tx = 1'b0;
        begin_txn(in_t, a, e, wd);
        for (int att = 0; att < MAX_ATT; att++) begin
            tx_phase("token_pkt");
            if (!in_t) begin
                tx_phase("data0_pkt");
                case (plan[att])
                    0: rx_send(PID_ACK, {$urandom(), $urandom()}, 1'b1);
                    3: rx_send(PID_ACK, {$urandom(), $urandom()}, 1'b0);
                    default: rx_send(PID_NAK, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
                endcase
                if (plan[att] == 0) break;
`ifdef PROTO_TIMEOUT_EN
            end else if (plan[att] < 0) begin
                timeout_wait();
`endif
            end else begin
                if (long_wait) begin
                    n_bad_silence(300);
                end
                repeat (plan[att]) begin
                    k = junk_bad_only ? 0 : $urandom_range(0, 2);
                    case (k)
                        0: rx_send(PID_DATA0, {$urandom(), $urandom()}, 1'b0);
                        1: rx_send(PID_NAK, {$urandom(), $urandom()}, 1'b1);
                        default: rx_send(PID_ACK, {$urandom(), $urandom()}, 1'b1);
                    endcase
                    #1;
                    `CHK("ignored_pkt_no_ack", pkt_in_avail, 1'b0);
                    `CHK("ignored_pkt_still_rx", re, 1'b1);
                end
                rx_send(PID_DATA0, rd, 1'b1);
                tx_phase("ack_pkt");
                break;
            end
        end
        finish_check();
    endtask

    task automatic n_bad_silence(int cycles);
        int bad = 0;
        encoder_ready = 1'b1;
        repeat (cycles) begin
            #1;
            if (re !== 1'b1 || pkt_in_avail !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        `CHK("rx_waits_indefinitely", bad, 0);
    endtask

    initial begin
        logic        r_in;
        logic [98:0] dummy;
        int          n;
        rst_b = 1'b0; start = 1'b0; is_in = 1'b0; addr = '0; endp = '0; data_wr = '0;
        encoder_ready = 1'b0; nrzi_avail = 1'b0; pkt_out = '0; pkt_out_avail = 1'b0;
        data_good = 1'b0; decoder_ready = 1'b1;
        model_rd = '0; junk_bad_only = 1'b0; long_wait = 1'b0; fast_tx = 1'b0;
        repeat (3) step();
        #1;
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_done", done, 1'b0);
        `CHK("rst_success", success, 1'b0);
        `CHK("rst_pkt_in", pkt_in, 99'd0);
        `CHK("rst_pkt_in_avail", pkt_in_avail, 1'b0);
        `CHK("rst_data_rd", data_rd, 64'd0);
        `CHK("rst_re", re, 1'b1);
        rst_b = 1'b1;
        step();

        fill_plan(1); plan[0] = 0;
        run_txn(1'b0, 7'h05, 4'h1, 64'hDEADBEEF_01234567, 64'd0);

        fill_plan(0);
        run_txn(1'b1, 7'h05, 4'h1, 64'd0, 64'h0123_4567_89AB_CDEF);

        fill_plan(1);
        run_txn(1'b0, 7'h05, 4'h1, 64'h1111_2222_3333_4444, 64'd0);
        `CHK("nak_token_count", tok_seen, MAX_ATT);

        fill_plan(0); plan[0] = 1; junk_bad_only = 1'b1;
        run_txn(1'b1, 7'h0A, 4'h3, 64'd0, 64'hCAFE_F00D_5555_AAAA);
        junk_bad_only = 1'b0;

`ifdef PROTO_TIMEOUT_EN
        fill_plan(-1);
        run_txn(1'b1, 7'h05, 4'h2, 64'd0, 64'h9999_8888_7777_6666);
        `CHK("timeout_token_count", tok_seen, MAX_ATT);
`else
        fill_plan(0); long_wait = 1'b1;
        run_txn(1'b1, 7'h21, 4'h4, 64'd0, 64'h0F0F_1234_ABCD_0001);
        long_wait = 1'b0;
`endif

        // Reset in the middle of a line transmission.
        begin_txn(1'b0, 7'h11, 4'h3, 64'hA5A5_A5A5_5A5A_5A5A);
        encoder_ready = 1'b1;
        n = 0;
        #1;
        while (pkt_in_avail !== 1'b1 && n < 20) begin step(); #1; n++; end
        `CHK("rst_test_strobe", pkt_in_avail, 1'b1);
        step(); nrzi_avail = 1'b1; step(); step();
        rst_b = 1'b0;
        #1;
        `CHK("rst_test_in_tx_wait", re, 1'b0);
        step();
        rst_b = 1'b1;
        #1;
        model_rd = '0;
        `CHK("midrst_busy", busy, 1'b0);
        `CHK("midrst_re", re, 1'b1);
        `CHK("midrst_pkt_in", pkt_in, 99'd0);
        `CHK("midrst_pkt_in_avail", pkt_in_avail, 1'b0);
        `CHK("midrst_done", done, 1'b0);
        `CHK("midrst_data_rd", data_rd, model_rd);
        step();
        nrzi_avail = 1'b0;
        step();
        fill_plan(1); plan[0] = 0;
        run_txn(1'b0, 7'h12, 4'h5, 64'h0000_1111_2222_3333, 64'd0);

        for (int t = 0; t < 12; t++) begin
            r_in = 1'($urandom_range(0, 1));
            for (int i = 0; i < MAX_ATT; i++) begin
                if (r_in) begin
                    plan[i] = $urandom_range(0, 2);
`ifdef PROTO_TIMEOUT_EN
                    if ($urandom_range(0, 3) == 0) plan[i] = -1;
`endif
                end else begin
                    plan[i] = $urandom_range(0, 3);
                end
            end
            dummy = rand99();
            run_txn(r_in, dummy[6:0], dummy[10:7], {$urandom(), $urandom()},
                    {$urandom(), $urandom()});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
